// File: rtl/rf_writeback_arbiter.sv
// rf_writeback_arbiter: merges ALU and long-latency results onto the register-file write port
module rf_writeback_arbiter #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 32
) (
    input  logic            clk,
    input  logic            reset_n,
    input  logic            a_valid,
    input  logic [4:0]      a_rd,
    input  logic [XLEN-1:0] a_data,
    input  logic            b_valid,
    output logic            b_ready,
    input  logic [4:0]      b_rd,
    input  logic [XLEN-1:0] b_data,
    output logic            we3,
    output logic [4:0]      wa3,
    output logic [XLEN-1:0] wd3,
    output logic [31:0]     pend_mask,
    output logic            idle
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);

    logic [4:0]      q_rd   [DEPTH];
    logic [XLEN-1:0] q_data [DEPTH];
    logic [DEPTH-1:0] q_vld;
    logic [PW-1:0]   wr_ptr, rd_ptr;
    logic [CW-1:0]   count;
    logic            wr_from_b;
    logic            a_win, b_hs, b_real, head_win, bypass, push, pop;

    // Arbitration: ALU first, then queued long-latency results, then a same-cycle bypass when the queue is empty
    always_comb begin
        b_ready  = reset_n && (count < FULL);
        a_win    = a_valid && (a_rd != 5'd0);
        b_hs     = b_valid && b_ready;
        b_real   = b_hs && (b_rd != 5'd0);
        head_win = !a_win && (count != '0);
        bypass   = !a_win && (count == '0) && b_real;
        push     = b_real && !bypass;
        pop      = head_win;
        idle     = (count == '0) && !we3;
    end

    // Queue storage needs no reset: the per-slot valid bits gate every use of it
    always_ff @(posedge clk) begin
        if (push) begin
            q_rd[wr_ptr]   <= b_rd;
            q_data[wr_ptr] <= b_data;
        end
    end

    // Queue bookkeeping: pointers wrap modulo DEPTH, simultaneous push and pop leave count unchanged
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            q_vld  <= '0;
        end else begin
            wr_ptr <= push ? wr_ptr + 1'b1 : wr_ptr;
            rd_ptr <= pop ? rd_ptr + 1'b1 : rd_ptr;
            count  <= (push && !pop) ? count + 1'b1 : (pop && !push) ? count - 1'b1 : count;
            for (int i = 0; i < DEPTH; i++) begin
                if (push && PW'(i) == wr_ptr)
                    q_vld[i] <= 1'b1;
                else if (pop && PW'(i) == rd_ptr)
                    q_vld[i] <= 1'b0;
            end
        end
    end

    // Write register: loads the arbitration winner every cycle; address and data hold when idle
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            we3       <= 1'b0;
            wa3       <= '0;
            wd3       <= '0;
            wr_from_b <= 1'b0;
        end else begin
            we3       <= a_win || head_win || bypass;
            wa3       <= a_win ? a_rd : head_win ? q_rd[rd_ptr] : bypass ? b_rd : wa3;
            wd3       <= a_win ? a_data : head_win ? q_data[rd_ptr] : bypass ? b_data : wd3;
            wr_from_b <= head_win || bypass;
        end
    end

    // Pending mask from registered state only: queued entries plus an in-flight long-latency write
    always_comb begin
        pend_mask = '0;
        for (int i = 0; i < DEPTH; i++)
            if (q_vld[i]) pend_mask[q_rd[i]] = 1'b1;
        if (we3 && wr_from_b) pend_mask[wa3] = 1'b1;
    end
endmodule

// File: tb/tb_rf_writeback_arbiter.sv
// tb_rf_writeback_arbiter: directed scenario checks of the write-back arbiter
module tb_rf_writeback_arbiter;
    logic        clk = 1'b0;
    logic        reset_n;
    logic        a_valid;
    logic [4:0]  a_rd;
    logic [31:0] a_data;
    logic        b_valid;
    logic        b_ready;
    logic [4:0]  b_rd;
    logic [31:0] b_data;
    logic        we3;
    logic [4:0]  wa3;
    logic [31:0] wd3;
    logic [31:0] pend_mask;
    logic        idle;
    int errors = 0;
    int checks = 0;

    rf_writeback_arbiter #(.DEPTH(4), .XLEN(32)) dut (
        .clk(clk), .reset_n(reset_n),
        .a_valid(a_valid), .a_rd(a_rd), .a_data(a_data),
        .b_valid(b_valid), .b_ready(b_ready), .b_rd(b_rd), .b_data(b_data),
        .we3(we3), .wa3(wa3), .wd3(wd3), .pend_mask(pend_mask), .idle(idle)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; a_valid = 1'b0; a_rd = '0; a_data = '0;
        b_valid = 1'b1; b_rd = 5'd3; b_data = 32'h5;
        #1;
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL reset_b_ready got %b exp 0", b_ready); end
        tick(); tick();
        checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL reset_we3 got %b exp 0", we3); end
        checks++; if (wa3 !== 5'd0) begin errors++; $display("FAIL reset_wa3 got %0d exp 0", wa3); end
        checks++; if (wd3 !== 32'd0) begin errors++; $display("FAIL reset_wd3 got %h exp 0", wd3); end
        checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL reset_pend got %h exp 0", pend_mask); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle got %b exp 1", idle); end
        b_valid = 1'b0;
        reset_n = 1'b1;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL post_reset_b_ready got %b exp 1", b_ready); end
    endtask

    task automatic test_a_write();
        a_valid = 1'b1; a_rd = 5'd5; a_data = 32'h11;
        tick();
        a_valid = 1'b0;
        checks++; if (we3 !== 1'b1) begin errors++; $display("FAIL a_we3 got %b exp 1", we3); end
        checks++; if (wa3 !== 5'd5) begin errors++; $display("FAIL a_wa3 got %0d exp 5", wa3); end
        checks++; if (wd3 !== 32'h11) begin errors++; $display("FAIL a_wd3 got %h exp 11", wd3); end
        checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL a_pend got %h exp 0", pend_mask); end
        tick();
        checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL a_we3_after got %b exp 0", we3); end
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL a_idle_after got %b exp 1", idle); end
    endtask

    task automatic test_b_bypass();
        b_valid = 1'b1; b_rd = 5'd7; b_data = 32'hAB;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL byp_ready got %b exp 1", b_ready); end
        tick();
        b_valid = 1'b0;
        checks++; if (we3 !== 1'b1) begin errors++; $display("FAIL byp_we3 got %b exp 1", we3); end
        checks++; if (wa3 !== 5'd7) begin errors++; $display("FAIL byp_wa3 got %0d exp 7", wa3); end
        checks++; if (wd3 !== 32'hAB) begin errors++; $display("FAIL byp_wd3 got %h exp ab", wd3); end
        checks++; if (pend_mask !== 32'h80) begin errors++; $display("FAIL byp_pend got %h exp 80", pend_mask); end
        checks++; if (idle !== 1'b0) begin errors++; $display("FAIL byp_idle got %b exp 0", idle); end
        tick();
        checks++; if (pend_mask !== 32'd0) begin errors++; $display("FAIL byp_pend_clear got %h exp 0", pend_mask); end
        checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL byp_we3_after got %b exp 0", we3); end
    endtask

    task automatic test_same_cycle();
        a_valid = 1'b1; a_rd = 5'd3; a_data = 32'h1;
        b_valid = 1'b1; b_rd = 5'd4; b_data = 32'h2;
        tick();
        a_valid = 1'b0; b_valid = 1'b0;
        checks++; if (wa3 !== 5'd3 || wd3 !== 32'h1 || we3 !== 1'b1) begin errors++; $display("FAIL same_first got we=%b wa=%0d wd=%h exp 1 3 1", we3, wa3, wd3); end
        checks++; if (pend_mask !== 32'h10) begin errors++; $display("FAIL same_pend1 got %h exp 10", pend_mask); end
        tick();
        checks++; if (wa3 !== 5'd4 || wd3 !== 32'h2 || we3 !== 1'b1) begin errors++; $display("FAIL same_second got we=%b wa=%0d wd=%h exp 1 4 2", we3, wa3, wd3); end
        checks++; if (pend_mask !== 32'h10) begin errors++; $display("FAIL same_pend2 got %h exp 10", pend_mask); end
        tick();
        checks++; if (pend_mask !== 32'd0 || we3 !== 1'b0) begin errors++; $display("FAIL same_done got pend=%h we=%b exp 0 0", pend_mask, we3); end
    endtask

    task automatic test_fill_drain();
        a_valid = 1'b1; a_rd = 5'd1; a_data = 32'h55;
        b_valid = 1'b1;
        for (int i = 0; i < 4; i++) begin
            b_rd = 5'(8 + i); b_data = 32'h108 + 32'(i);
            #1;
            checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL fill_ready%0d got %b exp 1", i, b_ready); end
            tick();
            checks++; if (wa3 !== 5'd1 || we3 !== 1'b1) begin errors++; $display("FAIL fill_a_write%0d got we=%b wa=%0d exp 1 1", i, we3, wa3); end
        end
        b_rd = 5'd12; b_data = 32'h10C;
        #1;
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL full_ready got %b exp 0", b_ready); end
        checks++; if (pend_mask !== 32'h0F00) begin errors++; $display("FAIL full_pend got %h exp 0f00", pend_mask); end
        a_valid = 1'b0;
        #1;
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL full_drain_ready got %b exp 0", b_ready); end
        for (int k = 0; k < 6; k++) begin
            tick();
            checks++; if (we3 !== 1'b1 || wa3 !== 5'(8 + k) || wd3 !== 32'h108 + 32'(k)) begin errors++; $display("FAIL drain%0d got we=%b wa=%0d wd=%h exp 1 %0d %h", k, we3, wa3, wd3, 8 + k, 32'h108 + 32'(k)); end
            if (k == 0) begin
                checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL drain_ready got %b exp 1", b_ready); end
                checks++; if (pend_mask !== 32'h0F00) begin errors++; $display("FAIL drain_pend got %h exp 0f00", pend_mask); end
            end
            if (k == 1) begin b_rd = 5'd13; b_data = 32'h10D; end
            if (k == 2) b_valid = 1'b0;
        end
        tick();
        checks++; if (we3 !== 1'b0 || pend_mask !== 32'd0 || idle !== 1'b1) begin errors++; $display("FAIL drain_end got we=%b pend=%h idle=%b exp 0 0 1", we3, pend_mask, idle); end
    endtask

    task automatic test_rd_zero();
        a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h22;
        b_valid = 1'b1; b_rd = 5'd9; b_data = 32'h99;
        tick();
        b_valid = 1'b0;
        a_rd = 5'd0; a_data = 32'hEE;
        checks++; if (pend_mask !== 32'h200) begin errors++; $display("FAIL rd0_queued_pend got %h exp 200", pend_mask); end
        tick();
        a_valid = 1'b0;
        checks++; if (we3 !== 1'b1 || wa3 !== 5'd9 || wd3 !== 32'h99) begin errors++; $display("FAIL rd0_head got we=%b wa=%0d wd=%h exp 1 9 99", we3, wa3, wd3); end
        b_valid = 1'b1; b_rd = 5'd0; b_data = 32'h77;
        #1;
        checks++; if (b_ready !== 1'b1) begin errors++; $display("FAIL brd0_ready got %b exp 1", b_ready); end
        tick();
        b_valid = 1'b0;
        checks++; if (we3 !== 1'b0 || pend_mask !== 32'd0 || idle !== 1'b1) begin errors++; $display("FAIL brd0_drop got we=%b pend=%h idle=%b exp 0 0 1", we3, pend_mask, idle); end
        tick();
        checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL brd0_never got we=%b exp 0", we3); end
    endtask

    task automatic test_reset_mid();
        a_valid = 1'b1; a_rd = 5'd2; a_data = 32'h22;
        b_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin
            b_rd = 5'(20 + i); b_data = 32'h200 + 32'(i);
            tick();
        end
        b_valid = 1'b0;
        checks++; if (pend_mask !== 32'h0070_0000) begin errors++; $display("FAIL mid_pend got %h exp 700000", pend_mask); end
        reset_n = 1'b0; a_valid = 1'b0;
        b_valid = 1'b1; b_rd = 5'd23; b_data = 32'h333;
        #1;
        checks++; if (b_ready !== 1'b0) begin errors++; $display("FAIL mid_ready got %b exp 0", b_ready); end
        tick();
        checks++; if (we3 !== 1'b0 || pend_mask !== 32'd0) begin errors++; $display("FAIL mid_reset got we=%b pend=%h exp 0 0", we3, pend_mask); end
        reset_n = 1'b1; b_valid = 1'b0;
        #1;
        checks++; if (idle !== 1'b1) begin errors++; $display("FAIL mid_idle got %b exp 1", idle); end
        for (int i = 0; i < 4; i++) begin
            tick();
            checks++; if (we3 !== 1'b0) begin errors++; $display("FAIL mid_flush%0d got we=%b wa=%0d exp we 0", i, we3, wa3); end
        end
    endtask

    initial begin
        test_reset();
        test_a_write();
        test_b_bypass();
        test_same_cycle();
        test_fill_drain();
        test_rd_zero();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/rf_writeback_arbiter.md
Name: rf_writeback_arbiter

Overview:
- Sole writer of the three-ported register file's write port (we3/wa3/wd3).
- Merges two result sources onto that single port:
  - Source A: the single-cycle ALU path. It has priority and no backpressure.
  - Source B: the long-latency path (load/multiply). It uses valid/ready and is buffered in a DEPTH-entry FIFO.
- Exports a pending-write mask so the hazard unit can stall readers of registers with queued writes.

Parameters:
- DEPTH, 4, B-queue entries; power of two, >= 2.
- XLEN, 32, data width.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- reset_n  input  1  synchronous active-low reset, sampled on rising edge of clk.
- a_valid  input  1  source A result valid this cycle; always accepted.
- a_rd  input  5  source A destination register.
- a_data  input  XLEN  source A result.
- b_valid  input  1  source B result valid.
- b_ready  output  1  arbiter can accept source B this cycle.
- b_rd  input  5  source B destination register.
- b_data  input  XLEN  source B result.
- we3  output  1  register-file write enable (registered).
- wa3  output  5  register-file write address (registered).
- wd3  output  XLEN  register-file write data (registered).
- pend_mask  output  32  bit r = 1 while a source-B write to r is queued or in the write register.
- idle  output  1  queue empty and no write in flight.

Behaviour:
- Reset (reset_n low at edge):
  - we3=0, wa3=0, wd3=0; FIFO count=0; pend_mask=0.
  - b_ready forced 0 combinationally while reset_n is low.
  - Any in-flight or queued write is discarded. Reset mid-burst loses queued B results by design.
- Write register: we3/wa3/wd3 load every cycle from the winner of arbitration. Winner in cycle N means we3=1 during N+1, and the register-file write completes at the end of N+1.
- Arbitration priority, each cycle:
  - (1) A: a_valid=1 and a_rd!=0.
  - (2) FIFO head, if count>0.
  - (3) B bypass: FIFO empty and B handshake this cycle.
  - (4) None: we3<=0; wa3/wd3 hold.
- A with a_rd=0: ignored entirely, and the slot goes to priority 2/3.
- B handshake: b_valid && b_ready.
  - b_rd=0: accepted and discarded (not enqueued, no mask update).
  - Otherwise: if it wins via bypass, it goes straight to the write register (latency 1). Else it is pushed to the FIFO tail.
- b_ready = (count < DEPTH). It does not account for a same-cycle pop, so a full FIFO accepts nothing even when draining.
- Simultaneous push and pop of FIFO: count unchanged; pointers wrap modulo DEPTH.
- Ordering:
  - B results leave in acceptance order.
  - No WAW filtering between A and B. The issue/hazard logic must stall any instruction whose rd hits pend_mask.
- pend_mask: OR of one-hot(rd) over all valid FIFO entries, plus the write register if its content came from B.
  - Computed from registered state only, with no combinational path from inputs.
  - Bit set from cycle N+1 after acceptance in N.
  - Bit cleared the cycle after the final we3 cycle for that register.
- idle = (count==0) && !we3.
- A starvation is impossible. B may starve under continuous A writes; this is intentional.

Test Plan:
- Reset, then a_valid=1, a_rd=5, a_data=0x11 -> next cycle we3=1, wa3=5, wd3=0x11; following cycle we3=0, idle=1.
- Idle, b_valid=1, b_rd=7, b_data=0xAB -> b_ready=1; next cycle we3=1, wa3=7, wd3=0xAB, pend_mask=0x80; following cycle pend_mask=0.
- Same cycle: A (rd=3, 0x1) and B (rd=4, 0x2) -> cycle+1 writes x3=0x1, cycle+2 writes x4=0x2; pend_mask bit4 set for cycles +1..+2.
- A writes every cycle while B offers 6 results (rd=8..13), DEPTH=4:
  - 4 are accepted, then b_ready=0, pend_mask=0x0F00.
  - Drop a_valid: B results drain in order x8..x13 over consecutive cycles, and b_ready returns to 1 after the first pop.
- a_valid=1 with a_rd=0 while B head rd=9 is queued -> B head is written that cycle (wa3=9); no write to x0. B with b_rd=0 -> accepted, never written, pend_mask unchanged.
- Queue holding 3 entries, reset_n=0 for one edge -> we3=0, pend_mask=0, b_ready=0 during reset, idle=1 afterwards; no queued data is ever written.
